// File: rtl/alu_op_pkg.sv
// Shared types for the execute-stage ALU: operation codes, FSM states and
// small classification helpers used by the top level and the combinational core.
package alu_op_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_XOR = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_AND = 4'b0100,
        ALU_SLT = 4'b0101,
        ALU_SRA = 4'b0110,
        ALU_SRL = 4'b0111,
        ALU_SLL = 4'b1000,
        ALU_BNE = 4'b1010,
        ALU_BLT = 4'b1011,
        ALU_BGE = 4'b1100,
        ALU_BEQ = 4'b1101,
        ALU_LUI = 4'b1110
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SRA) || (op == ALU_SRL) || (op == ALU_SLL);
    endfunction

    function automatic logic is_branch(input logic [3:0] op);
        return (op == ALU_BNE) || (op == ALU_BLT) || (op == ALU_BGE) || (op == ALU_BEQ);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Combinational single-cycle ALU: result, branch condition and illegal-code
// detection for every non-shift operation code.
module alu_comb_core
    import alu_op_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [3:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_taken,
    output logic                  o_illegal
);

    logic signed [DATA_WIDTH-1:0] w_a_s;
    logic signed [DATA_WIDTH-1:0] w_b_s;
    logic                         w_lt;
    logic                         w_eq;
    logic                         w_cond;

    assign w_a_s = i_a;
    assign w_b_s = i_b;
    assign w_lt  = (w_a_s < w_b_s);
    assign w_eq  = (i_a == i_b);

    always_comb begin
        w_cond    = 1'b0;
        o_result  = '0;
        o_illegal = 1'b0;
        case (i_op)
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_XOR: o_result = i_a ^ i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_AND: o_result = i_a & i_b;
            ALU_SLT: o_result = {{(DATA_WIDTH-1){1'b0}}, w_lt};
            ALU_BNE: w_cond = !w_eq;
            ALU_BLT: w_cond = w_lt;
            ALU_BGE: w_cond = !w_lt;
            ALU_BEQ: w_cond = w_eq;
            ALU_LUI: o_result = i_b;
            // Shift codes are produced by the iterative datapath in the top level
            ALU_SRA, ALU_SRL, ALU_SLL: o_result = '0;
            default: o_illegal = 1'b1;
        endcase
        if (is_branch(i_op)) begin
            o_result = {{(DATA_WIDTH-1){1'b0}}, w_cond};
        end
        o_taken = w_cond;
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes: single-cycle ops via
// alu_comb_core, shifts iterated SHIFT_STEP bits per cycle.
module alu_exec_unit
    import alu_op_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            operation,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  branch_taken,
    output logic                  illegal_op
);

    localparam int SHW = $clog2(DATA_WIDTH);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_branch;
    logic                  r_illegal;
    logic [DATA_WIDTH-1:0] r_result;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [SHW-1:0]        r_cnt;
    logic [3:0]            r_kind;

    logic                  w_accept;
    logic                  w_out_fire;
    logic                  w_is_shift;
    logic [SHW-1:0]        w_shamt;
    logic [SHW-1:0]        w_step;
    logic [SHW-1:0]        w_cnt_nxt;
    logic [DATA_WIDTH-1:0] w_acc_shifted;
    logic [DATA_WIDTH-1:0] w_core_result;
    logic                  w_core_taken;
    logic                  w_core_illegal;

    alu_comb_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .i_op      (operation),
        .i_a       (src_a),
        .i_b       (src_b),
        .o_result  (w_core_result),
        .o_taken   (w_core_taken),
        .o_illegal (w_core_illegal)
    );

    assign w_accept   = in_valid && r_in_ready && (r_state == IDLE);
    assign w_out_fire = r_out_valid && out_ready;
    assign w_is_shift = is_shift(operation);
    assign w_shamt    = src_b[SHW-1:0];

    // Last step may be shorter than SHIFT_STEP so the total equals shamt exactly
    always_comb begin
        if (int'(r_cnt) < SHIFT_STEP) begin
            w_step = r_cnt;
        end else begin
            w_step = SHW'(SHIFT_STEP);
        end
        w_cnt_nxt = r_cnt - w_step;
        case (r_kind)
            ALU_SRA: w_acc_shifted = DATA_WIDTH'($signed(r_acc) >>> w_step);
            ALU_SRL: w_acc_shifted = r_acc >> w_step;
            default: w_acc_shifted = r_acc << w_step;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_shift && (w_shamt != '0)) begin
                        w_state_nxt = SHIFT;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            SHIFT: begin
                if (w_cnt_nxt == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (w_out_fire) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake flags track the next state so they are registered yet cycle-accurate
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_branch    <= 1'b0;
            r_illegal   <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_kind      <= 4'b0000;
        end else begin
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_is_shift) begin
                            r_acc     <= src_a;
                            r_cnt     <= w_shamt;
                            r_kind    <= operation;
                            r_branch  <= 1'b0;
                            r_illegal <= 1'b0;
                            if (w_shamt == '0) begin
                                r_result <= src_a;
                            end
                        end else begin
                            r_result  <= w_core_result;
                            r_branch  <= w_core_taken;
                            r_illegal <= w_core_illegal;
                        end
                    end
                end
                SHIFT: begin
                    r_acc <= w_acc_shifted;
                    r_cnt <= w_cnt_nxt;
                    if (w_cnt_nxt == '0) begin
                        r_result <= w_acc_shifted;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign result       = r_result;
    assign branch_taken = r_branch;
    assign illegal_op   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table over all code classes plus
// stall, reset and latency sequences; a second instance uses SHIFT_STEP=4.
module tb_alu_exec_unit;
    import alu_op_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  operation = 4'b0000;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;

    logic        in_ready, out_valid, branch_taken, illegal_op;
    logic [31:0] result;
    logic        in_ready4, out_valid4, branch_taken4, illegal_op4;
    logic [31:0] result4;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.DATA_WIDTH(32), .SHIFT_STEP(1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .operation(operation), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .branch_taken(branch_taken), .illegal_op(illegal_op)
    );

    alu_exec_unit #(.DATA_WIDTH(32), .SHIFT_STEP(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .operation(operation), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid4), .out_ready(out_ready), .result(result4),
        .branch_taken(branch_taken4), .illegal_op(illegal_op4)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        tk;
        logic        il;
        int          lat;
        int          lat4;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int g;
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("issue_in_ready", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        operation = op;
        src_a     = a;
        src_b     = b;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        operation = 4'(ALU_XOR);
        src_a     = 32'hDEAD_BEEF;
        src_b     = 32'h1234_5677;
    endtask

    task automatic wait_valid(output int lat, output int lat4, output logic [31:0] r4);
        lat  = 1;
        lat4 = 0;
        r4   = '0;
        while (!out_valid && lat < 200) begin
            if (out_valid4 && lat4 == 0) begin
                lat4 = lat;
                r4   = result4;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        if (out_valid4 && lat4 == 0) begin
            lat4 = lat;
            r4   = result4;
        end
    endtask

    initial begin
        int          lat, lat4, seen;
        logic [31:0] r4;

        vecs[0]  = '{4'(ALU_SUB), 32'd5,          32'd7,          32'hFFFF_FFFE, 1'b0, 1'b0, 1,  1};
        vecs[1]  = '{4'(ALU_ADD), 32'hFFFF_FFFF,  32'd2,          32'h0000_0001, 1'b0, 1'b0, 1,  1};
        vecs[2]  = '{4'(ALU_XOR), 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0, 1'b0, 1'b0, 1,  1};
        vecs[3]  = '{4'(ALU_OR),  32'h0000_00F0,  32'h0F00_0000,  32'h0F00_00F0, 1'b0, 1'b0, 1,  1};
        vecs[4]  = '{4'(ALU_AND), 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000, 1'b0, 1'b0, 1,  1};
        vecs[5]  = '{4'(ALU_SLT), 32'hFFFF_FFFF,  32'd1,          32'h0000_0001, 1'b0, 1'b0, 1,  1};
        vecs[6]  = '{4'(ALU_SRA), 32'h8000_0000,  32'd4,          32'hF800_0000, 1'b0, 1'b0, 5,  2};
        vecs[7]  = '{4'(ALU_SRL), 32'h8000_0000,  32'hFFFF_FFE4,  32'h0800_0000, 1'b0, 1'b0, 5,  2};
        vecs[8]  = '{4'(ALU_SLL), 32'd1,          32'd0,          32'h0000_0001, 1'b0, 1'b0, 1,  1};
        vecs[9]  = '{4'(ALU_SLL), 32'd1,          32'd31,         32'h8000_0000, 1'b0, 1'b0, 32, 9};
        vecs[10] = '{4'(ALU_BLT), 32'hFFFF_FFFF,  32'd1,          32'h0000_0001, 1'b1, 1'b0, 1,  1};
        vecs[11] = '{4'(ALU_BGE), 32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 1'b0, 1'b0, 1,  1};
        vecs[12] = '{4'(ALU_BEQ), 32'd9,          32'd9,          32'h0000_0001, 1'b1, 1'b0, 1,  1};
        vecs[13] = '{4'(ALU_BNE), 32'd9,          32'd9,          32'h0000_0000, 1'b0, 1'b0, 1,  1};
        vecs[14] = '{4'b1001,     32'd5,          32'd3,          32'h0000_0000, 1'b0, 1'b1, 1,  1};
        vecs[15] = '{4'(ALU_LUI), 32'd7,          32'h1234_5000,  32'h1234_5000, 1'b0, 1'b0, 1,  1};
        vecs[16] = '{4'b1111,     32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 1'b0, 1'b1, 1,  1};
        vecs[17] = '{4'(ALU_SRA), 32'h8000_0000,  32'd5,          32'hFC00_0000, 1'b0, 1'b0, 6,  3};

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",     32'(in_ready),     32'd0);
        chk("rst_out_valid",    32'(out_valid),    32'd0);
        chk("rst_result",       result,            32'd0);
        chk("rst_branch_taken", 32'(branch_taken), 32'd0);
        chk("rst_illegal_op",   32'(illegal_op),   32'd0);
        chk("rst_in_ready4",    32'(in_ready4),    32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel_in_ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_after_edge", 32'(in_ready), 32'd1);

        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_valid(lat, lat4, r4);
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid),    32'd1);
            chk($sformatf("v%0d_latency", i),   32'(lat),          32'(vecs[i].lat));
            chk($sformatf("v%0d_result", i),    result,            vecs[i].res);
            chk($sformatf("v%0d_branch", i),    32'(branch_taken), 32'(vecs[i].tk));
            chk($sformatf("v%0d_illegal", i),   32'(illegal_op),   32'(vecs[i].il));
            chk($sformatf("v%0d_latency4", i),  32'(lat4),         32'(vecs[i].lat4));
            chk($sformatf("v%0d_result4", i),   r4,                vecs[i].res);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid_drop", i), 32'(out_valid), 32'd0);
            chk($sformatf("v%0d_ready_back", i), 32'(in_ready),  32'd1);
        end

        // Downstream stall: result must hold and new requests are ignored
        out_ready = 1'b0;
        issue(4'(ALU_ADD), 32'h10, 32'h20);
        wait_valid(lat, lat4, r4);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_result",    result,         32'h30);
        @(negedge clk);
        in_valid  = 1'b1;
        operation = 4'(ALU_SUB);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_result", c),   result,         32'h30);
            chk($sformatf("stall%0d_valid", c),    32'(out_valid), 32'd1);
            chk($sformatf("stall%0d_in_ready", c), 32'(in_ready),  32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_release_valid", 32'(out_valid), 32'd0);
        chk("stall_release_ready", 32'(in_ready),  32'd1);
        chk("stall_release_result", result,        32'h30);

        // Reset asserted while a long shift is in progress
        issue(4'(ALU_SLL), 32'd1, 32'd31);
        repeat (5) @(posedge clk);
        #1;
        chk("midshift_busy", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midshift_rst_valid",  32'(out_valid), 32'd0);
        chk("midshift_rst_ready",  32'(in_ready),  32'd0);
        chk("midshift_rst_result", result,         32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid || out_valid4) seen = 1;
        end
        chk("midshift_no_valid", 32'(seen),     32'd0);
        chk("midshift_idle",     32'(in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "timeout");
    end

endmodule
